pulse_scheduler: RTL and testbench
==================================

Name: pulse_scheduler

Overview:
- Sequences pulse descriptors out of the pulse FIFO against a global sequence timer.
- Pops one descriptor at a time and holds it until the timer reaches its absolute start time.
- Then drives the pulse generator for tlen cycles, stepping the envelope address.
- Sits between the pulse FIFO (head-of-queue, show-ahead read) and the NCO/envelope playback datapath.

Parameters:
- PHASE_W, 16, phase field width
- AMP_W, 16, amplitude field width
- FREQ_W, 32, frequency field width
- TSTART_W, 32, absolute start time and timer width
- TLEN_W, 16, pulse length width (cycles)
- ENV_ADDR_W, 10, envelope memory address width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low
- start  in  1  begin sequence (honoured only in IDLE)
- stop  in  1  abort sequence, return to IDLE
- fifo_empty  in  1  pulse FIFO empty
- fifo_phase  in  PHASE_W  head-of-FIFO phase (valid while !fifo_empty)
- fifo_amp  in  AMP_W  head amplitude
- fifo_freq  in  FREQ_W  head frequency
- fifo_tstart  in  TSTART_W  head absolute start time
- fifo_tlen  in  TLEN_W  head length
- fifo_env_addr  in  ENV_ADDR_W  head envelope base address
- fifo_pop  out  1  pop head this cycle
- busy  out  1  state != IDLE
- now  out  TSTART_W  sequence timer
- active  out  1  pulse playing this cycle
- out_phase  out  PHASE_W  phase of playing pulse
- out_amp  out  AMP_W  amplitude of playing pulse
- out_freq  out  FREQ_W  frequency of playing pulse
- env_addr  out  ENV_ADDR_W  envelope sample address
- pulse_count  out  16  pulses completed since start
- late_err  out  1  sticky: a pulse started after its tstart
- timer_ovf  out  1  sticky: timer saturated

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; all outputs 0, including now, the sticky flags and the latched fields.
- Registered outputs: all except fifo_pop, which is combinational from state, fifo_empty and the PLAY counter.
- States: IDLE, FETCH, WAIT, PLAY.
- Timer:
  - The cycle after start is accepted, now=0.
  - Increments by 1 every cycle while busy.
  - At all-ones it holds and sets timer_ovf.
  - Cleared only by start or reset.
- IDLE:
  - start=1 -> FETCH next cycle; clears now, pulse_count, late_err and timer_ovf.
  - start is ignored in any other state.
- Pop event: fifo_pop=1 and latch all head fields. Allowed only in FETCH or on the last PLAY cycle, with fifo_empty=0. Next state is decided at pop:
  - tlen==0: pulse discarded (counted, no active cycle); next state FETCH.
  - now+1 >= tstart: next state PLAY. If now+1 > tstart, set late_err.
  - otherwise: next state WAIT.
- FETCH with fifo_empty=1: stay in FETCH; timer keeps running.
- WAIT: when now+1 == tstart -> PLAY. An on-time pulse therefore has its first active cycle at now==tstart. The earliest on-time tstart is 1.
- PLAY:
  - active=1 for exactly tlen cycles.
  - env_addr = latched base + k for k=0..tlen-1, truncated to ENV_ADDR_W (wraps).
  - out_* hold the latched values.
  - Last cycle: pulse_count+1 (wraps at 2^16).
  - Last cycle, fifo_empty=0: pop per the pop rules. Back-to-back pulses with tstart(n+1)=tstart(n)+tlen(n) play with no gap.
  - Last cycle, fifo_empty=1: -> FETCH.
- Outside PLAY: active=0. out_* and env_addr are driven to 0.
- stop=1 in any busy state: IDLE next cycle.
  - active drops that cycle; no pop that cycle.
  - now, pulse_count and the sticky flags hold.
  - An in-flight latched pulse is discarded and not counted.
- stop and start in the same cycle while IDLE: stop wins; stays IDLE.
- Reset mid-PLAY: active=0 and state IDLE on the next edge; no pop is issued.
- fifo_pop is never asserted when fifo_empty=1 or in IDLE/WAIT.

Test Plan:
1. Single pulse on time: start; FIFO holds {tstart=5, tlen=3, env=0x10, amp=0x1234} -> pop at now=0; active at now=5,6,7; env_addr 0x10,0x11,0x12; pulse_count=1; late_err=0; FETCH afterwards.
2. Back-to-back: {tstart=4, tlen=2} then {tstart=6, tlen=3} -> active continuous now=4..8; second pop on now=5; env_addr restarts at the second base on now=6; pulse_count=2.
3. Late and zero-length pulses:
   - {tstart=0, tlen=2} -> plays at now=1,2; late_err=1.
   - Following {tstart=3, tlen=0} -> popped, no active cycle, pulse_count increments.
4. Empty FIFO stall: start with an empty FIFO, push {tstart=20, tlen=1} at now=10 -> fifo_pop at the first cycle with !fifo_empty; single active cycle at now=20.
5. Abort: stop asserted at now=6 during a 4-cycle pulse starting now=5 -> active low from the next cycle; busy=0; pulse_count unchanged; a following start clears now to 0.
6. Env wrap and reset:
   - env base 0x3FE, tlen=4 -> env_addr 0x3FE, 0x3FF, 0x000, 0x001.
   - rst_n pulled low mid-pulse -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/pulse_scheduler.sv
// Pulse scheduler: pops timed pulse descriptors from a show-ahead FIFO, waits for each
// descriptor's absolute start time on the sequence timer, then plays it for tlen cycles.
module pulse_scheduler #(
  parameter int PHASE_W    = 16,
  parameter int AMP_W      = 16,
  parameter int FREQ_W     = 32,
  parameter int TSTART_W   = 32,
  parameter int TLEN_W     = 16,
  parameter int ENV_ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  fifo_empty,
  input  logic [PHASE_W-1:0]    fifo_phase,
  input  logic [AMP_W-1:0]      fifo_amp,
  input  logic [FREQ_W-1:0]     fifo_freq,
  input  logic [TSTART_W-1:0]   fifo_tstart,
  input  logic [TLEN_W-1:0]     fifo_tlen,
  input  logic [ENV_ADDR_W-1:0] fifo_env_addr,
  output logic                  fifo_pop,
  output logic                  busy,
  output logic [TSTART_W-1:0]   now,
  output logic                  active,
  output logic [PHASE_W-1:0]    out_phase,
  output logic [AMP_W-1:0]      out_amp,
  output logic [FREQ_W-1:0]     out_freq,
  output logic [ENV_ADDR_W-1:0] env_addr,
  output logic [15:0]           pulse_count,
  output logic                  late_err,
  output logic                  timer_ovf
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, PLAY} state_t;

  typedef struct packed {
    logic [PHASE_W-1:0]    phase;
    logic [AMP_W-1:0]      amp;
    logic [FREQ_W-1:0]     freq;
    logic [TSTART_W-1:0]   tstart;
    logic [TLEN_W-1:0]     tlen;
    logic [ENV_ADDR_W-1:0] env;
  } desc_t;

  state_t                state, state_next;
  desc_t                 head, cur, sel;
  logic [TLEN_W-1:0]     k;
  logic [TSTART_W:0]     now_p1;
  logic                  last, pop, late_set, accept, play_start, play_on;
  logic [1:0]            done_inc;

  assign head   = {fifo_phase, fifo_amp, fifo_freq, fifo_tstart, fifo_tlen, fifo_env_addr};
  // One bit wider so the start-time comparison stays correct when the timer is saturated.
  assign now_p1 = {1'b0, now} + (TSTART_W+1)'(1);
  assign last   = (k == cur.tlen - TLEN_W'(1));

  assign busy     = (state != IDLE);
  assign active   = (state == PLAY);
  assign fifo_pop = pop;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    late_set   = 1'b0;
    accept     = 1'b0;
    done_inc   = 2'd0;

    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_next = FETCH;
          accept     = 1'b1;
        end
      end
      FETCH: begin
        if (stop)             state_next = IDLE;
        else if (!fifo_empty) pop = 1'b1;
      end
      WAIT: begin
        if (stop)                               state_next = IDLE;
        else if (now_p1 == {1'b0, cur.tstart})  state_next = PLAY;
      end
      PLAY: begin
        if (stop) begin
          state_next = IDLE;
        end else if (last) begin
          done_inc = 2'd1;
          if (!fifo_empty) pop = 1'b1;
          else             state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase

    // The head's fate is decided in the cycle it is popped.
    if (pop) begin
      if (head.tlen == '0) begin
        done_inc   = done_inc + 2'd1;
        state_next = FETCH;
      end else if (now_p1 >= {1'b0, head.tstart}) begin
        state_next = PLAY;
        late_set   = (now_p1 > {1'b0, head.tstart});
      end else begin
        state_next = WAIT;
      end
    end

    sel        = pop ? head : cur;
    play_start = (state_next == PLAY) && (pop || (state == WAIT));
    play_on    = (state_next == PLAY) && !play_start;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the latched descriptor is a handful of flops, not a memory, so it is
      // reset along with everything else and never leaks stale fields.
      state       <= IDLE;
      cur         <= '0;
      k           <= '0;
      now         <= '0;
      pulse_count <= '0;
      late_err    <= 1'b0;
      timer_ovf   <= 1'b0;
      out_phase   <= '0;
      out_amp     <= '0;
      out_freq    <= '0;
      env_addr    <= '0;
    end else begin
      state <= state_next;
      if (pop) cur <= head;

      if (accept) begin
        now         <= '0;
        pulse_count <= '0;
        late_err    <= 1'b0;
        timer_ovf   <= 1'b0;
      end else begin
        if (busy && !stop) begin
          if (&now) timer_ovf <= 1'b1;
          else      now       <= now + TSTART_W'(1);
        end
        pulse_count <= pulse_count + 16'(done_inc);
        if (late_set) late_err <= 1'b1;
      end

      if (play_start)   k <= '0;
      else if (play_on) k <= k + TLEN_W'(1);

      if (state_next == PLAY) begin
        out_phase <= sel.phase;
        out_amp   <= sel.amp;
        out_freq  <= sel.freq;
      end else begin
        out_phase <= '0;
        out_amp   <= '0;
        out_freq  <= '0;
      end

      if (play_start)   env_addr <= sel.env;
      else if (play_on) env_addr <= env_addr + ENV_ADDR_W'(1);
      else              env_addr <= '0;
    end
  end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler: a FIFO model feeds descriptors, a monitor checks
// every pop and every active cycle against queued expectations.
module tb_pulse_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, fifo_empty, fifo_pop, busy, active, late_err, timer_ovf;
  logic [15:0] fifo_phase, fifo_amp, fifo_tlen, out_phase, out_amp, pulse_count;
  logic [31:0] fifo_freq, fifo_tstart, now, out_freq;
  logic [9:0]  fifo_env_addr, env_addr;

  always #5 clk = ~clk;

  pulse_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .fifo_empty(fifo_empty), .fifo_phase(fifo_phase), .fifo_amp(fifo_amp),
    .fifo_freq(fifo_freq), .fifo_tstart(fifo_tstart), .fifo_tlen(fifo_tlen),
    .fifo_env_addr(fifo_env_addr), .fifo_pop(fifo_pop), .busy(busy), .now(now),
    .active(active), .out_phase(out_phase), .out_amp(out_amp), .out_freq(out_freq),
    .env_addr(env_addr), .pulse_count(pulse_count), .late_err(late_err),
    .timer_ovf(timer_ovf)
  );

  typedef struct {
    logic [15:0] phase;
    logic [15:0] amp;
    logic [31:0] freq;
    logic [31:0] tstart;
    logic [15:0] tlen;
    logic [9:0]  env;
  } desc_t;

  typedef struct {
    logic [31:0] now;
    logic [9:0]  env;
    logic [15:0] phase;
    logic [15:0] amp;
    logic [31:0] freq;
  } act_t;

  desc_t       fq[$];
  desc_t       stage_q[$];
  act_t        exp_act[$];
  logic [31:0] exp_pop[$];
  int          n_vec = 0;
  int          n_miss = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic desc_t mk(input logic [15:0] phase, input logic [15:0] amp,
                               input logic [31:0] freq, input logic [31:0] tstart,
                               input logic [15:0] tlen, input logic [9:0] env);
    desc_t d;
    d.phase = phase; d.amp = amp; d.freq = freq;
    d.tstart = tstart; d.tlen = tlen; d.env = env;
    return d;
  endfunction

  // FIFO model: pops seen in a cycle take effect just after the edge; staged pushes land then too.
  initial begin
    bit pop_seen;
    fifo_empty = 1'b1;
    fifo_phase = '0; fifo_amp = '0; fifo_freq = '0;
    fifo_tstart = '0; fifo_tlen = '0; fifo_env_addr = '0;
    forever begin
      @(negedge clk);
      pop_seen = (fifo_pop === 1'b1);
      @(posedge clk);
      #1;
      if (pop_seen && fq.size() > 0) void'(fq.pop_front());
      while (stage_q.size() > 0) fq.push_back(stage_q.pop_front());
      fifo_empty = (fq.size() == 0);
      if (fq.size() > 0) begin
        fifo_phase = fq[0].phase; fifo_amp = fq[0].amp; fifo_freq = fq[0].freq;
        fifo_tstart = fq[0].tstart; fifo_tlen = fq[0].tlen; fifo_env_addr = fq[0].env;
      end else begin
        fifo_phase = '0; fifo_amp = '0; fifo_freq = '0;
        fifo_tstart = '0; fifo_tlen = '0; fifo_env_addr = '0;
      end
    end
  end

  // Monitor: every pop and every active cycle consumes one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (fifo_pop) begin
          check("pop_while_empty", fifo_empty, 0);
          if (exp_pop.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL unexpected_pop: now=%0d, no pop expected", now);
          end else begin
            check("pop_now", now, exp_pop.pop_front());
          end
        end
        if (active) begin
          if (exp_act.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL unexpected_active: now=%0d env=%0h, no pulse expected", now, env_addr);
          end else begin
            act_t e;
            e = exp_act.pop_front();
            check("act_now", now, e.now);
            check("act_env", env_addr, e.env);
            check("act_amp", out_amp, e.amp);
            check("act_phase", out_phase, e.phase);
            check("act_freq", out_freq, e.freq);
          end
        end else begin
          check("idle_out_zero", {63'b0, |{out_phase, out_amp, out_freq, env_addr}}, 0);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_play(input desc_t d, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      act_t a;
      a.now = 32'(first + i);
      a.env = d.env + 10'(i);
      a.phase = d.phase; a.amp = d.amp; a.freq = d.freq;
      exp_act.push_back(a);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_to_idle", busy, 0);
  endtask

  task automatic drained(input string tag);
    check({tag, "_act_left"}, exp_act.size(), 0);
    check({tag, "_pop_left"}, exp_pop.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    desc_t d1, d2a, d2b, d3a, d3b, d4, d5, d6a, d6b;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_now", now, 0);
    check("rst_active", active, 0);
    check("rst_count", pulse_count, 0);
    check("rst_late", late_err, 0);
    check("rst_ovf", timer_ovf, 0);
    check("rst_pop", fifo_pop, 0);
    check("rst_env", env_addr, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // 1: single on-time pulse
    d1 = mk(16'h0011, 16'h1234, 32'hABCD0001, 5, 3, 10'h010);
    stage_q.push_back(d1);
    tick();
    exp_pop.push_back(0);
    expect_play(d1, 5, 3);
    do_start();
    check("t1_start_now", now, 0);
    tick(11);
    check("t1_now", now, 11);
    check("t1_count", pulse_count, 1);
    check("t1_late", late_err, 0);
    check("t1_fetch_busy", busy, 1);
    drained("t1");
    do_stop();

    // 2: back-to-back pulses, no gap
    d2a = mk(16'h0022, 16'h2222, 32'h00000222, 4, 2, 10'h020);
    d2b = mk(16'h0033, 16'h3333, 32'h00000333, 6, 3, 10'h040);
    stage_q.push_back(d2a);
    stage_q.push_back(d2b);
    tick();
    exp_pop.push_back(0);
    exp_pop.push_back(5);
    expect_play(d2a, 4, 2);
    expect_play(d2b, 6, 3);
    do_start();
    tick(12);
    check("t2_count", pulse_count, 2);
    check("t2_late", late_err, 0);
    drained("t2");
    do_stop();

    // 3: late pulse then zero-length pulse
    d3a = mk(16'h0055, 16'h5555, 32'h00000555, 0, 2, 10'h050);
    d3b = mk(16'h0066, 16'h0006, 32'h00000666, 3, 0, 10'h060);
    stage_q.push_back(d3a);
    stage_q.push_back(d3b);
    tick();
    exp_pop.push_back(0);
    exp_pop.push_back(2);
    expect_play(d3a, 1, 2);
    do_start();
    tick(6);
    check("t3_count", pulse_count, 2);
    check("t3_late", late_err, 1);
    check("t3_ovf", timer_ovf, 0);
    drained("t3");
    do_stop();
    check("t3_late_held", late_err, 1);

    // 4: start on an empty FIFO; entry present from now=10
    do_start();
    check("t4_late_cleared", late_err, 0);
    check("t4_count_cleared", pulse_count, 0);
    tick(9);
    check("t4_now", now, 9);
    d4 = mk(16'h0077, 16'h7777, 32'h00000777, 20, 1, 10'h077);
    stage_q.push_back(d4);
    exp_pop.push_back(10);
    expect_play(d4, 20, 1);
    tick(14);
    check("t4_count", pulse_count, 1);
    drained("t4");
    do_stop();

    // 5: abort mid-pulse
    d5 = mk(16'h0088, 16'h8888, 32'h00000888, 5, 4, 10'h080);
    stage_q.push_back(d5);
    tick();
    exp_pop.push_back(0);
    expect_play(d5, 5, 2);
    do_start();
    tick(6);
    check("t5_active_pre", active, 1);
    check("t5_now_pre", now, 6);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t5_active_post", active, 0);
    check("t5_busy_post", busy, 0);
    check("t5_count", pulse_count, 0);
    drained("t5");
    do_start();
    check("t5_restart_now", now, 0);
    check("t5_restart_busy", busy, 1);
    do_stop();

    // 6: envelope address wrap, then reset mid-pulse
    d6a = mk(16'h0099, 16'h9999, 32'h00000999, 2, 4, 10'h3FE);
    d6b = mk(16'h00AA, 16'hAAAA, 32'h00000AAA, 8, 5, 10'h100);
    stage_q.push_back(d6a);
    stage_q.push_back(d6b);
    tick();
    exp_pop.push_back(0);
    exp_pop.push_back(5);
    expect_play(d6a, 2, 4);
    expect_play(d6b, 8, 2);
    do_start();
    tick(9);
    check("t6_now", now, 9);
    check("t6_active_pre", active, 1);
    check("t6_count_pre", pulse_count, 1);
    rst_n = 1'b0;
    tick();
    check("t6_rst_active", active, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_now", now, 0);
    check("t6_rst_count", pulse_count, 0);
    check("t6_rst_env", env_addr, 0);
    check("t6_rst_amp", out_amp, 0);
    check("t6_rst_freq", out_freq, 0);
    check("t6_rst_pop", fifo_pop, 0);
    rst_n = 1'b1;
    drained("t6");

    // start and stop together in IDLE: stop wins
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", busy, 0);
    tick(2);
    check("startstop_now", now, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
